lmsm_sequencer: RTL and testbench



---
 rtl/lmsm_sequencer_pkg.sv | 31 +++
 rtl/lmsm_priority_enc.sv | 41 ++++
 rtl/lmsm_sequencer.sv | 135 +++++++++++++
 tb/tb_lmsm_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/lmsm_sequencer_pkg.sv
// Shared definitions for the LM/SM sequencer and the decoder.
//   - Register-list width and register address width
//   - LM/SM opcodes and instruction field bit positions
//   - Sequencer state encoding
//   - Helper that recognises an LM/SM opcode
package lmsm_sequencer_pkg;

  localparam int LIST_W = 8;   // one list bit per architectural register
  localparam int REG_AW = 3;   // clog2(LIST_W)

  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  // Instruction field positions
  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 12;
  localparam int BASE_HI = 11;
  localparam int BASE_LO = 9;
  localparam int LIST_HI = 7;
  localparam int LIST_LO = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic logic is_lmsm(input logic [3:0] opc);
    return (opc == OP_LM) || (opc == OP_SM);
  endfunction

endpackage

// File: rtl/lmsm_priority_enc.sv
// Combinational lowest-set-bit finder for the remaining register list.
// Ports:
//   list      in   LIST_W  remaining (unissued) register bits
//   low_idx   out  REG_AW  index of the lowest set bit (0 when list is empty)
//   clr_mask  out  LIST_W  one-hot mask of that bit (all zero when empty)
//   valid     out  1       list has at least one bit set
//   one_left  out  1       list has exactly one bit set
module lmsm_priority_enc #(
  parameter int LIST_W = 8,
  parameter int REG_AW = 3
) (
  input  logic [LIST_W-1:0] list,
  output logic [REG_AW-1:0] low_idx,
  output logic [LIST_W-1:0] clr_mask,
  output logic              valid,
  output logic              one_left
);

  logic [LIST_W-1:0] rest;

  // x & -x isolates the lowest set bit
  assign clr_mask = list & (~list + LIST_W'(1));
  // x & (x-1) drops the lowest set bit; empty afterwards means one bit was set
  assign rest     = list & (list - LIST_W'(1));
  assign valid    = |list;
  assign one_left = valid && (rest == '0);

  // One-hot to binary: index bit gi is the OR of all list positions whose
  // index has bit gi set.
  genvar gi, gj;
  generate
    for (gi = 0; gi < REG_AW; gi++) begin : g_idx
      logic [LIST_W-1:0] sel;
      for (gj = 0; gj < LIST_W; gj++) begin : g_sel
        assign sel[gj] = 1'((gj >> gi) & 1);
      end
      assign low_idx[gi] = |(clr_mask & sel);
    end
  endgenerate

endmodule

// File: rtl/lmsm_sequencer.sv
// LM/SM expansion controller for the register-read stage. Turns one
// Load-Multiple / Store-Multiple instruction into one micro-op per set bit
// of its register list, lowest register first.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   inst_valid   decode presents a valid instruction word
//   inst_word    [15:12] opcode, [11:9] base register, [7:0] register list
//   hold         downstream stall; freezes the sequencer
//   flush        kill the in-flight LM/SM
//   stall_out    hold fetch/decode
//   op_valid     a micro-op is presented this cycle
//   op_load      1 = LM (write op_reg), 0 = SM (read op_reg)
//   op_reg       register address of this micro-op
//   op_base      base register of the current LM/SM
//   op_offset    micro-op index; address = R[op_base] + op_offset
//   op_last      final micro-op of the instruction
module lmsm_sequencer
  import lmsm_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_valid,
  input  logic [15:0]       inst_word,
  input  logic              hold,
  input  logic              flush,
  output logic              stall_out,
  output logic              op_valid,
  output logic              op_load,
  output logic [REG_AW-1:0] op_reg,
  output logic [REG_AW-1:0] op_base,
  output logic [REG_AW-1:0] op_offset,
  output logic              op_last
);

  state_t              state_reg, state_next;
  logic [LIST_W-1:0]   list_reg, list_next;
  logic [REG_AW-1:0]   offset_reg, offset_next;
  logic [REG_AW-1:0]   base_reg, base_next;
  logic                load_reg, load_next;

  logic [REG_AW-1:0]   low_idx;
  logic [LIST_W-1:0]   clr_mask;
  logic                list_nz;
  logic                one_left;

  logic [3:0]          inst_opc;
  logic [REG_AW-1:0]   inst_base;
  logic [LIST_W-1:0]   inst_list;
  logic                busy;
  logic                last_now;
  logic                accept;
  logic                unused_bit8;

  assign inst_opc    = inst_word[OPC_HI:OPC_LO];
  assign inst_base   = inst_word[BASE_HI:BASE_LO];
  assign inst_list   = inst_word[LIST_HI:LIST_LO];
  // Bit 8 is not a field of LM/SM
  assign unused_bit8 = inst_word[8];

  lmsm_priority_enc #(
    .LIST_W (LIST_W),
    .REG_AW (REG_AW)
  ) u_penc (
    .list     (list_reg),
    .low_idx  (low_idx),
    .clr_mask (clr_mask),
    .valid    (list_nz),
    .one_left (one_left)
  );

  assign busy     = (state_reg == ST_BUSY) && list_nz;
  assign last_now = busy && one_left;

  // A new instruction may enter while the previous one issues its last op,
  // so back-to-back LM/SM run without a bubble.
  assign accept = inst_valid && is_lmsm(inst_opc) && (inst_list != '0) &&
                  !hold && !flush && (!busy || last_now);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      list_reg   <= '0;
      offset_reg <= '0;
      base_reg   <= '0;
      load_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      list_reg   <= list_next;
      offset_reg <= offset_next;
      base_reg   <= base_next;
      load_reg   <= load_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    list_next   = list_reg;
    offset_next = offset_reg;
    base_next   = base_reg;
    load_next   = load_reg;

    if (flush) begin
      state_next  = ST_IDLE;
      list_next   = '0;
      offset_next = '0;
    end else if (!hold) begin
      if (busy) begin
        list_next   = list_reg & ~clr_mask;
        offset_next = offset_reg + REG_AW'(1);
        if (last_now) begin
          state_next  = ST_IDLE;
          offset_next = '0;
        end
      end
      if (accept) begin
        state_next  = ST_BUSY;
        list_next   = inst_list;
        offset_next = '0;
        base_next   = inst_base;
        load_next   = (inst_opc == OP_LM);
      end
    end
  end

  // All micro-op outputs come from registered state only
  assign op_valid  = busy;
  assign op_reg    = busy ? low_idx : '0;
  assign op_offset = busy ? offset_reg : '0;
  assign op_base   = busy ? base_reg : '0;
  assign op_load   = busy && load_reg;
  assign op_last   = last_now;
  // Under hold even the last op must keep decode stalled
  assign stall_out = busy && (!one_left || hold);

endmodule

// File: tb/tb_lmsm_sequencer.sv
module tb_lmsm_sequencer;

  localparam logic [3:0] LM = 4'b0110;
  localparam logic [3:0] SM = 4'b0111;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_valid;
  logic [15:0] inst_word;
  logic        hold;
  logic        flush;
  logic        stall_out;
  logic        op_valid;
  logic        op_load;
  logic [2:0]  op_reg;
  logic [2:0]  op_base;
  logic [2:0]  op_offset;
  logic        op_last;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lmsm_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .inst_valid (inst_valid),
    .inst_word  (inst_word),
    .hold       (hold),
    .flush      (flush),
    .stall_out  (stall_out),
    .op_valid   (op_valid),
    .op_load    (op_load),
    .op_reg     (op_reg),
    .op_base    (op_base),
    .op_offset  (op_offset),
    .op_last    (op_last)
  );

  // Reference: queue of micro-ops still to be presented, front = current one
  typedef struct {
    int  rg;
    int  off;
    bit  last;
    bit  load;
    int  base;
  } uop_t;

  uop_t pend_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(input logic [3:0] opc, input logic [2:0] base,
                                     input logic [7:0] list);
    return {opc, base, 1'b0, list};
  endfunction

  // One clock: apply inputs, check outputs mid-cycle, advance the model.
  task automatic step(input logic v, input logic [15:0] w, input logic h,
                      input logic f, input logic r);
    bit        acc;
    int        n;
    int        k;
    logic [7:0] lst;
    uop_t      u;
    inst_valid = v;
    inst_word  = w;
    hold       = h;
    flush      = f;
    reset      = r;
    @(negedge clk);

    check_eq("op_valid", op_valid, pend_q.size() != 0);
    check_eq("stall_out", stall_out, (pend_q.size() > 1) || (pend_q.size() == 1 && h));
    if (pend_q.size() != 0) begin
      check_eq("op_reg", op_reg, pend_q[0].rg);
      check_eq("op_offset", op_offset, pend_q[0].off);
      check_eq("op_last", op_last, pend_q[0].last);
      check_eq("op_load", op_load, pend_q[0].load);
      check_eq("op_base", op_base, pend_q[0].base);
    end else begin
      check_eq("op_last_idle", op_last, 0);
    end

    lst = w[7:0];
    acc = v && (w[15:12] == LM || w[15:12] == SM) && lst != 0 && !h && !f &&
          pend_q.size() <= 1;
    if (r || f) begin
      pend_q.delete();
    end else if (!h) begin
      if (pend_q.size() != 0) void'(pend_q.pop_front());
      if (acc) begin
        n = $countones(lst);
        k = 0;
        for (int i = 0; i < 8; i++) begin
          if (lst[i]) begin
            u.rg = i; u.off = k; u.last = (k == n - 1);
            u.load = (w[15:12] == LM); u.base = int'(w[11:9]);
            pend_q.push_back(u);
            k++;
          end
        end
        $display("accept %s base=%0d list=%02h ops=%0d at %0t",
                 (w[15:12] == LM) ? "LM" : "SM", w[11:9], lst, n, $time);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0]  opc;
    logic [7:0]  lst;
    logic [15:0] w;
    int          sel;

    inst_valid = 1'b0; inst_word = '0; hold = 1'b0; flush = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    #1;
    check_eq("rst_op_reg", op_reg, 0);
    check_eq("rst_op_offset", op_offset, 0);
    check_eq("rst_op_base", op_base, 0);
    check_eq("rst_op_load", op_load, 0);
    check_eq("rst_op_last", op_last, 0);

    // Reset while busy, then a normal LM
    step(1'b1, mk(LM, 3'd1, 8'hFF), 1'b0, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    idle(1);
    step(1'b1, mk(LM, 3'd4, 8'h06), 1'b0, 1'b0, 1'b0);
    idle(3);

    // LM base 2, list A5
    step(1'b1, mk(LM, 3'd2, 8'hA5), 1'b0, 1'b0, 1'b0);
    idle(5);

    // SM single bit
    step(1'b1, mk(SM, 3'd6, 8'h80), 1'b0, 1'b0, 1'b0);
    idle(2);

    // Back-to-back LM 03 then SM 10 during LM's last op
    step(1'b1, mk(LM, 3'd3, 8'h03), 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b1, mk(SM, 3'd5, 8'h10), 1'b0, 1'b0, 1'b0);
    idle(2);

    // Hold for two cycles on op 2 of list 0F
    step(1'b1, mk(LM, 3'd0, 8'h0F), 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    idle(4);

    // Flush while reg 5 is showing, then a zero-list LM
    step(1'b1, mk(SM, 3'd7, 8'hF0), 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    step(1'b1, mk(LM, 3'd1, 8'h00), 1'b0, 1'b0, 1'b0);
    idle(2);

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      sel = $urandom_range(0, 9);
      opc = (sel < 4) ? LM : (sel < 8) ? SM : 4'($urandom);
      sel = $urandom_range(0, 9);
      lst = (sel == 0) ? 8'h00 : (sel < 3) ? (8'h01 << $urandom_range(0, 7)) : 8'($urandom);
      w = {opc, 3'($urandom), 1'($urandom), lst};
      step($urandom_range(0, 9) < 7, w, $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 2);
    end
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
